// File: rtl/loopback_pipe_pkg.sv
// Shared types and the word transform for the loopback DUT emulator.
// The transform works on a wide container; callers pass their real width.
package loopback_pkg;

   localparam int unsigned LB_MAX_W = 64;

   typedef enum logic [1:0] {
      LB_PASS = 2'b00,
      LB_INV  = 2'b01,
      LB_INC  = 2'b10,
      LB_SWAP = 2'b11
   } lb_mode_e;

   typedef enum logic [1:0] {
      LB_IDLE  = 2'b00,
      LB_RUN   = 2'b01,
      LB_DRAIN = 2'b10
   } lb_state_e;

   // d must be zero above bit width-1; the result is masked to width bits
   function automatic logic [LB_MAX_W-1:0] lb_xform(input lb_mode_e    mode,
                                                    input logic [LB_MAX_W-1:0] d,
                                                    input int unsigned width);
      logic [LB_MAX_W-1:0] mask;
      logic [LB_MAX_W-1:0] r;
      int unsigned         half;
      mask = {LB_MAX_W{1'b1}} >> (LB_MAX_W - width);
      half = width / 32'd2;
      case (mode)
         LB_PASS: r = d;
         LB_INV:  r = ~d;
         LB_INC:  r = d + 64'd1;
         LB_SWAP: r = (d >> half) | (d << half);
         default: r = d;
      endcase
      return r & mask;
   endfunction

endpackage

// File: rtl/loopback_pipe_if.sv
// Stimulus/result FIFO handshake and status bundle of loopback_pipe.
// slave is the DUT view, master is the bench/board view.
interface loopback_pipe_if #(
   parameter int DATA_WIDTH = 24,
   parameter int CNT_WIDTH  = 16
) ();

   logic                  enable;
   logic [1:0]            mode;
   logic [DATA_WIDTH-1:0] sfifo_data;
   logic                  sfifo_rdempty;
   logic                  sfifo_rdreq;
   logic [DATA_WIDTH-1:0] rfifo_data;
   logic                  rfifo_wrreq;
   logic                  rfifo_wrfull;
   logic                  busy;
   logic [CNT_WIDTH-1:0]  word_count;
   logic                  fault_flag;

   modport slave (
      input  enable, mode, sfifo_data, sfifo_rdempty, rfifo_wrfull,
      output sfifo_rdreq, rfifo_data, rfifo_wrreq, busy, word_count, fault_flag
   );

   modport master (
      output enable, mode, sfifo_data, sfifo_rdempty, rfifo_wrfull,
      input  sfifo_rdreq, rfifo_data, rfifo_wrreq, busy, word_count, fault_flag
   );

endinterface

// File: rtl/loopback_pipe_delay_line.sv
// lb_delay_line: stallable valid/data shift line; the whole line moves or
// the whole line holds, bubbles included.
module lb_delay_line #(
   parameter int DATA_WIDTH = 24,
   parameter int DELAY      = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  advance,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  any_valid
);

   logic [DELAY-1:0]      valid_q;
   logic [DELAY-1:0]      valid_d;
   logic [DATA_WIDTH-1:0] data_q [DELAY];
   logic [DATA_WIDTH-1:0] data_d [DELAY];

   // next line contents: shift by one on advance, otherwise hold
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (advance) begin
         valid_d[0] = in_valid;
         data_d[0]  = in_data;
         for (int i = 1; i < DELAY; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
         end
      end else begin
         valid_d = valid_q;
         data_d  = data_q;
      end
   end

   // stage registers; reset discards everything in flight
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= {DELAY{1'b0}};
         data_q  <= '{default: {DATA_WIDTH{1'b0}}};
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      out_valid = valid_q[DELAY-1];
      out_data  = data_q[DELAY-1];
      any_valid = |valid_q;
   end

endmodule

// File: rtl/loopback_pipe.sv
// loopback_pipe: pops stimulus words, transforms and delays them, pushes results.
// Optional fault injection on every FAULT_PERIOD-th push: LOOPBACK_PIPE_FAULT_EN.
module loopback_pipe
   import loopback_pkg::*;
#(
   parameter int DATA_WIDTH   = 24,
   parameter int DELAY        = 4,
   parameter int CNT_WIDTH    = 16,
   parameter int FAULT_PERIOD = 16
) (
   input  logic            clock,
   input  logic            reset_n,
   loopback_pipe_if.slave  bus
);

   localparam int unsigned XW = DATA_WIDTH;

   if ((DATA_WIDTH < 2) || (DATA_WIDTH % 2 != 0) || (DATA_WIDTH > LB_MAX_W) ||
       (DELAY < 1) || (CNT_WIDTH < 1) || (FAULT_PERIOD < 1)) begin : g_bad_params
      $error("loopback_pipe: illegal parameter combination");
   end

   logic                  stall_s;
   logic                  advance_s;
   logic                  pop_s;
   logic                  push_s;
   logic                  fault_s;
   logic                  out_valid_s;
   logic                  any_valid_s;
   logic [DATA_WIDTH-1:0] xform_s;
   logic [DATA_WIDTH-1:0] out_data_s;
   logic [DATA_WIDTH-1:0] rdata_s;

   lb_state_e             state_q;
   lb_state_e             state_d;
   logic [CNT_WIDTH-1:0]  count_q;
   logic [CNT_WIDTH-1:0]  count_d;

   // handshake: a full result FIFO only stalls when the output stage holds a word
   always_comb begin
      stall_s   = out_valid_s & bus.rfifo_wrfull;
      advance_s = ~stall_s;
      pop_s     = advance_s & bus.enable & ~bus.sfifo_rdempty;
      push_s    = out_valid_s & ~bus.rfifo_wrfull;
      xform_s   = DATA_WIDTH'(lb_xform(lb_mode_e'(bus.mode),
                                       LB_MAX_W'(bus.sfifo_data), XW));
   end

   lb_delay_line #(
      .DATA_WIDTH (DATA_WIDTH),
      .DELAY      (DELAY)
   ) u_line (
      .clock     (clock),
      .reset_n   (reset_n),
      .advance   (advance_s),
      .in_valid  (pop_s),
      .in_data   (xform_s),
      .out_valid (out_valid_s),
      .out_data  (out_data_s),
      .any_valid (any_valid_s)
   );

   // run/drain state machine
   always_comb begin
      state_d = state_q;
      case (state_q)
         LB_IDLE: begin
            if (bus.enable) state_d = LB_RUN;
            else            state_d = LB_IDLE;
         end
         LB_RUN: begin
            if (bus.enable)       state_d = LB_RUN;
            else if (any_valid_s) state_d = LB_DRAIN;
            else                  state_d = LB_IDLE;
         end
         LB_DRAIN: begin
            if (bus.enable)        state_d = LB_RUN;
            else if (!any_valid_s) state_d = LB_IDLE;
            else                   state_d = LB_DRAIN;
         end
         default: state_d = LB_IDLE;
      endcase
   end

   // saturating push counter
   always_comb begin
      count_d = count_q;
      if (push_s && (count_q != {CNT_WIDTH{1'b1}})) begin
         count_d = count_q + CNT_WIDTH'(1);
      end else begin
         count_d = count_q;
      end
   end

   // state and counter registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= LB_IDLE;
         count_q <= {CNT_WIDTH{1'b0}};
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

`ifdef LOOPBACK_PIPE_FAULT_EN
   localparam int PCNT_W = (FAULT_PERIOD > 1) ? $clog2(FAULT_PERIOD) : 1;

   logic [PCNT_W-1:0] pcnt_q;
   logic [PCNT_W-1:0] pcnt_d;

   // period counter advances on pushes only and wraps on the faulted push
   always_comb begin
      pcnt_d  = pcnt_q;
      fault_s = push_s & (pcnt_q == PCNT_W'(FAULT_PERIOD - 1));
      if (fault_s) begin
         pcnt_d = {PCNT_W{1'b0}};
      end else if (push_s) begin
         pcnt_d = pcnt_q + PCNT_W'(1);
      end else begin
         pcnt_d = pcnt_q;
      end
      rdata_s = out_data_s ^ {{(DATA_WIDTH-1){1'b0}}, fault_s};
   end

   // fault period register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pcnt_q <= {PCNT_W{1'b0}};
      end else begin
         pcnt_q <= pcnt_d;
      end
   end
`else
   always_comb begin
      fault_s = 1'b0;
      rdata_s = out_data_s;
   end
`endif

   assign bus.sfifo_rdreq = pop_s;
   assign bus.rfifo_wrreq = push_s;
   assign bus.rfifo_data  = rdata_s;
   assign bus.busy        = (state_q != LB_IDLE);
   assign bus.word_count  = count_q;
   assign bus.fault_flag  = fault_s;

endmodule

// File: tb/tb_loopback_pipe.sv
// Scoreboard bench for loopback_pipe: expected words are queued at pop time
// and compared in order at push time; FIFO ends are modelled by the bench.
module tb_loopback_pipe;

   localparam int DW = 24;
   localparam int CW = 16;
   localparam int FP = 4;
`ifdef LOOPBACK_PIPE_FAULT_EN
   localparam bit FAULT_ON = 1'b1;
`else
   localparam bit FAULT_ON = 1'b0;
`endif

   logic clk;
   logic rst_n;

   loopback_pipe_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

   loopback_pipe #(
      .DATA_WIDTH   (DW),
      .DELAY        (4),
      .CNT_WIDTH    (CW),
      .FAULT_PERIOD (FP)
   ) dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int n_pop = 0;
   int n_push = 0;
   int first_pop = -1;
   int first_push = -1;

   logic [DW-1:0] stim_q[$];
   logic [DW-1:0] exp_q[$];
   logic          en_r = 1'b0;
   logic [1:0]    mode_r = 2'b00;
   logic          full_r = 1'b0;
   logic          stall_chk = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] model(input logic [1:0] m, input logic [DW-1:0] d);
      case (m)
         2'b00:   return d;
         2'b01:   return ~d;
         2'b10:   return d + 24'd1;
         default: return {d[11:0], d[23:12]};
      endcase
   endfunction

   // one clock: drive at negedge, observe 1 ns later, score pops and pushes
   task automatic cycle();
      logic [DW-1:0] e;
      logic          ef;
      @(negedge clk);
      bus.enable       = en_r;
      bus.mode         = mode_r;
      bus.rfifo_wrfull = full_r;
      if (stim_q.size() != 0) begin
         bus.sfifo_rdempty = 1'b0;
         bus.sfifo_data    = stim_q[0];
      end else begin
         bus.sfifo_rdempty = 1'b1;
         bus.sfifo_data    = 24'h0;
      end
      #1;
      if (!en_r) check_eq("rdreq_disabled", bus.sfifo_rdreq, 1'b0);
      if (full_r) check_eq("wrreq_when_full", bus.rfifo_wrreq, 1'b0);
      if (stall_chk) check_eq("rdreq_stalled", bus.sfifo_rdreq, 1'b0);
      if (bus.sfifo_rdreq) begin
         if (stim_q.size() == 0) begin
            check_eq("pop_when_empty", 1'b1, 1'b0);
         end else begin
            exp_q.push_back(model(mode_r, stim_q[0]));
            void'(stim_q.pop_front());
            if (first_pop < 0) first_pop = cyc;
            n_pop++;
         end
      end
      if (bus.rfifo_wrreq) begin
         n_push++;
         if (first_push < 0) first_push = cyc;
         if (exp_q.size() == 0) begin
            check_eq("unexpected_push", bus.rfifo_data, 32'hDEAD);
         end else begin
            e  = exp_q.pop_front();
            ef = FAULT_ON && (n_push % FP == 0);
            if (ef) e = e ^ 24'h000001;
            check_eq("push_data", bus.rfifo_data, e);
            check_eq("fault_flag", bus.fault_flag, ef);
         end
      end
      cyc++;
   endtask

   task automatic run_until_drained(input string tag, input int max_cyc);
      int i;
      i = 0;
      while ((stim_q.size() != 0 || exp_q.size() != 0) && i < max_cyc) begin
         cycle();
         i++;
      end
      check_eq({tag, "_drained"}, (stim_q.size() == 0 && exp_q.size() == 0), 1'b1);
   endtask

   task automatic run_until_pops(input int target, input int max_cyc);
      int i;
      i = 0;
      while (n_pop < target && i < max_cyc) begin
         cycle();
         i++;
      end
      check_eq("pop_target", n_pop, target);
   endtask

   initial begin
      int base;
      int stall_left;
      bit stall_done;
      int i;

      rst_n             = 1'b0;
      bus.enable        = 1'b0;
      bus.mode          = 2'b00;
      bus.sfifo_data    = 24'h0;
      bus.sfifo_rdempty = 1'b1;
      bus.rfifo_wrfull  = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_eq("rst_rdreq", bus.sfifo_rdreq, 1'b0);
      check_eq("rst_wrreq", bus.rfifo_wrreq, 1'b0);
      check_eq("rst_busy", bus.busy, 1'b0);
      check_eq("rst_count", bus.word_count, 16'h0);
      check_eq("rst_rdata", bus.rfifo_data, 24'h0);
      check_eq("rst_fault", bus.fault_flag, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // pass-through and latency
      for (int k = 1; k <= 8; k++) stim_q.push_back(DW'(k));
      en_r = 1'b1;
      mode_r = 2'b00;
      run_until_drained("pass", 60);
      check_eq("latency", first_push - first_pop, 4);
      cycle();
      check_eq("count_pass", bus.word_count, 16'd8);
      check_eq("busy_run", bus.busy, 1'b1);

      // every transform, mode changed while earlier words are still in flight
      for (int m = 0; m < 4; m++) begin
         mode_r = 2'(m);
         stim_q.push_back(24'hFFFFFF);
         stim_q.push_back(24'h123456);
         i = 0;
         while (stim_q.size() != 0 && i < 20) begin
            cycle();
            i++;
         end
      end
      run_until_drained("xform", 40);

      // backpressure: 10 stalled cycles in the middle of 20 words
      mode_r = 2'b10;
      base = n_push;
      for (int k = 0; k < 20; k++) stim_q.push_back(DW'($urandom_range(0, 24'hFFFFFF)));
      stall_left = 0;
      stall_done = 1'b0;
      i = 0;
      while ((stim_q.size() != 0 || exp_q.size() != 0) && i < 200) begin
         if (!stall_done && n_push >= base + 5) begin
            full_r = 1'b1;
            stall_left = 10;
            stall_done = 1'b1;
         end
         stall_chk = full_r;
         cycle();
         if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) full_r = 1'b0;
         end
         i++;
      end
      stall_chk = 1'b0;
      full_r = 1'b0;
      check_eq("bp_drained", (stim_q.size() == 0 && exp_q.size() == 0), 1'b1);
      check_eq("bp_push_count", n_push - base, 20);
      cycle();
      check_eq("count_bp", bus.word_count, n_push);

      // drain: enable dropped after three pops
      mode_r = 2'b01;
      base = n_push;
      for (int k = 0; k < 10; k++) stim_q.push_back(DW'(24'h100 + k));
      run_until_pops(n_pop + 3, 20);
      en_r = 1'b0;
      cycle();
      cycle();
      check_eq("drain_busy", bus.busy, 1'b1);
      i = 0;
      while (bus.busy && i < 20) begin
         cycle();
         i++;
      end
      check_eq("drain_idle", bus.busy, 1'b0);
      check_eq("drain_pushes", n_push - base, 3);
      check_eq("drain_sb_empty", exp_q.size(), 0);
      repeat (3) cycle();
      stim_q.delete();

      // reset with four words in flight
      mode_r = 2'b00;
      for (int k = 0; k < 8; k++) stim_q.push_back(DW'(24'hA00 + k));
      en_r = 1'b1;
      base = n_push;
      run_until_pops(n_pop + 4, 20);
      check_eq("rst_mid_no_push_yet", n_push - base, 0);
      @(negedge clk);
      rst_n = 1'b0;
      en_r = 1'b0;
      bus.enable = 1'b0;
      #1;
      check_eq("rst_mid_wrreq", bus.rfifo_wrreq, 1'b0);
      check_eq("rst_mid_count", bus.word_count, 16'h0);
      check_eq("rst_mid_busy", bus.busy, 1'b0);
      check_eq("rst_mid_rdata", bus.rfifo_data, 24'h0);
      stim_q.delete();
      exp_q.delete();
      n_push = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) cycle();
      check_eq("rst_mid_stale", n_push, 0);
      check_eq("rst_mid_count_after", bus.word_count, 16'h0);

      // fault period: eight zero words
      en_r = 1'b1;
      for (int k = 0; k < 8; k++) stim_q.push_back(24'h000000);
      run_until_drained("fault", 40);
      cycle();
      check_eq("count_final", bus.word_count, 16'd8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
